// File: rtl/inst_decode_stage.sv
// Registered multi-lane instruction decode stage: per-lane RV decode into a control word,
// output register plus skid register under valid/ready, flush, and a saturating retire counter.

package rvga_pkg;
    typedef enum logic [2:0] {TypeR, TypeI, TypeS, TypeB, TypeU, TypeJ, TypeE} inst_type_e;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [6:0]  opcode;
        inst_type_e  itype;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        rs1_v;
        logic        rs2_v;
        logic        rd_w_v;
        logic        imm_v;
        logic        shift_v;
        logic        br_v;
    } cword_t;
endpackage

module inst_decode_stage
    import rvga_pkg::*;
#(
    parameter int unsigned LANES = 1,
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [31:0]           pc_i,
    input  logic [LANES-1:0]      lane_v_i,
    input  logic [LANES*32-1:0]   ir_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output cword_t [LANES-1:0]    decoded_o,
    output logic [LANES-1:0]      illegal_o,
    output logic [CNT_W-1:0]      dec_cnt_o
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    function automatic cword_t decode_lane(input logic [31:0] ir, input logic [31:0] pc,
                                           input logic v);
        cword_t c;
        logic   is_shift;
        c        = '0;
        c.v      = v;
        c.pc     = pc;
        c.opcode = ir[6:0];
        c.rs1    = ir[19:15];
        c.rs2    = ir[24:20];
        c.rd     = ir[11:7];
        c.funct3 = ir[14:12];
        c.funct7 = ir[31:25];
        c.itype  = TypeE;
        is_shift = (ir[14:12] == 3'b001) || (ir[14:12] == 3'b101);
        case (ir[6:0])
            OpLui: begin
                c.itype  = TypeU;
                c.imm    = {ir[31:12], 12'b0};
                c.rs1    = '0;
                c.funct3 = '0;
                c.funct7 = '0;
                c.imm_v  = 1'b1;
                c.rd_w_v = 1'b1;
            end
            OpAuipc: begin
                c.itype  = TypeU;
                c.imm    = {ir[31:12], 12'b0};
                c.imm_v  = 1'b1;
                c.rd_w_v = 1'b1;
            end
            OpJal: begin
                c.itype  = TypeJ;
                c.imm    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
                c.imm_v  = 1'b1;
                c.rd_w_v = 1'b1;
            end
            OpJalr: begin
                c.itype  = TypeI;
                c.imm    = {{20{ir[31]}}, ir[31:20]};
                c.funct3 = '0;
                c.funct7 = '0;
                c.rs1_v  = 1'b1;
                c.imm_v  = 1'b1;
                c.rd_w_v = 1'b1;
            end
            OpBranch: begin
                c.itype  = TypeB;
                c.imm    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                c.rs1_v  = 1'b1;
                c.rs2_v  = 1'b1;
                c.imm_v  = 1'b1;
                c.br_v   = 1'b1;
            end
            OpLoad: begin
                c.itype  = TypeI;
                c.imm    = {{20{ir[31]}}, ir[31:20]};
                c.rs1_v  = 1'b1;
                c.imm_v  = 1'b1;
                c.rd_w_v = 1'b1;
            end
            OpStore: begin
                c.itype  = TypeS;
                c.imm    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                c.rs1_v  = 1'b1;
                c.rs2_v  = 1'b1;
                c.imm_v  = 1'b1;
            end
            OpImm: begin
                c.itype   = TypeI;
                c.imm     = {{20{ir[31]}}, ir[31:20]};
                c.rs1_v   = 1'b1;
                c.imm_v   = 1'b1;
                c.rd_w_v  = 1'b1;
                c.shift_v = is_shift;
                if (!is_shift) c.funct7 = '0;
            end
            OpReg: begin
                c.itype   = TypeR;
                c.rs1_v   = 1'b1;
                c.rs2_v   = 1'b1;
                c.rd_w_v  = 1'b1;
                c.shift_v = is_shift;
            end
            default: ;
        endcase
        // An empty lane carries its raw fields but must not request any resource.
        if (!v) begin
            c.rs1_v   = 1'b0;
            c.rs2_v   = 1'b0;
            c.rd_w_v  = 1'b0;
            c.imm_v   = 1'b0;
            c.shift_v = 1'b0;
            c.br_v    = 1'b0;
        end
        return c;
    endfunction

    cword_t [LANES-1:0] in_dec;
    logic   [LANES-1:0] in_ill;
    cword_t [LANES-1:0] or_dec_q, or_dec_d, sk_dec_q, sk_dec_d;
    logic   [LANES-1:0] or_ill_q, or_ill_d, sk_ill_q, sk_ill_d;
    logic               or_v_q, or_v_d, sk_v_q, sk_v_d;
    logic   [CNT_W-1:0] cnt_q, cnt_d;
    logic   [CNT_W:0]   pop, sum;
    logic               accept, drain;

    always_comb begin
        in_dec = '0;
        in_ill = '0;
        for (int k = 0; k < LANES; k++) begin
            in_dec[k] = decode_lane(ir_i[32*k +: 32], pc_i + 32'(4 * k), lane_v_i[k]);
            in_ill[k] = lane_v_i[k] & (in_dec[k].itype == TypeE);
        end
    end

    assign ready_o = ~sk_v_q & ~reset_i;
    assign accept  = valid_i & ready_o & ~flush_i;
    assign drain   = or_v_q & ready_i;

    always_comb begin
        or_v_d   = or_v_q;
        or_dec_d = or_dec_q;
        or_ill_d = or_ill_q;
        sk_v_d   = sk_v_q;
        sk_dec_d = sk_dec_q;
        sk_ill_d = sk_ill_q;
        if (flush_i) begin
            or_v_d   = 1'b0;
            or_dec_d = '0;
            or_ill_d = '0;
            sk_v_d   = 1'b0;
            sk_dec_d = '0;
            sk_ill_d = '0;
        end else if (drain && sk_v_q) begin
            or_dec_d = sk_dec_q;
            or_ill_d = sk_ill_q;
            sk_v_d   = 1'b0;
        end else if (accept && (!or_v_q || drain)) begin
            or_v_d   = 1'b1;
            or_dec_d = in_dec;
            or_ill_d = in_ill;
        end else if (accept) begin
            sk_v_d   = 1'b1;
            sk_dec_d = in_dec;
            sk_ill_d = in_ill;
        end else if (drain) begin
            or_v_d = 1'b0;
        end
    end

    // Counter updates on the downstream handshake even in a flush cycle.
    always_comb begin
        pop = '0;
        for (int k = 0; k < LANES; k++) begin
            pop = pop + (CNT_W + 1)'(or_dec_q[k].v);
        end
        sum   = {1'b0, cnt_q} + pop;
        cnt_d = cnt_q;
        if (drain) begin
            cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            or_v_q   <= 1'b0;
            or_dec_q <= '0;
            or_ill_q <= '0;
            sk_v_q   <= 1'b0;
            sk_dec_q <= '0;
            sk_ill_q <= '0;
            cnt_q    <= '0;
        end else begin
            or_v_q   <= or_v_d;
            or_dec_q <= or_dec_d;
            or_ill_q <= or_ill_d;
            sk_v_q   <= sk_v_d;
            sk_dec_q <= sk_dec_d;
            sk_ill_q <= sk_ill_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_o   = or_v_q;
    assign decoded_o = or_dec_q;
    assign illegal_o = or_ill_q;
    assign dec_cnt_o = cnt_q;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench for inst_decode_stage: a decode vector table on a single-lane instance plus
// hand-written handshake, flush, saturation and reset sequences; a 2-lane instance covers lane PCs.

module tb_inst_decode_stage;
    import rvga_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush;

    // Single-lane instance with a 4-bit counter.
    logic         valid1, ready_o1, ready1, valid_o1;
    logic [31:0]  pc1;
    logic [0:0]   lv1;
    logic [31:0]  ir1;
    cword_t [0:0] dec1;
    logic [0:0]   ill1;
    logic [3:0]   cnt1;

    // Two-lane instance with a full-width counter.
    logic         valid2, ready_o2, ready2, valid_o2;
    logic [31:0]  pc2;
    logic [1:0]   lv2;
    logic [63:0]  ir2;
    cword_t [1:0] dec2;
    logic [1:0]   ill2;
    logic [31:0]  cnt2;

    inst_decode_stage #(.LANES(1), .CNT_W(4)) u1 (
        .clk_i(clk), .reset_i(reset), .flush_i(flush), .valid_i(valid1), .ready_o(ready_o1),
        .pc_i(pc1), .lane_v_i(lv1), .ir_i(ir1), .valid_o(valid_o1), .ready_i(ready1),
        .decoded_o(dec1), .illegal_o(ill1), .dec_cnt_o(cnt1)
    );

    inst_decode_stage #(.LANES(2), .CNT_W(32)) u2 (
        .clk_i(clk), .reset_i(reset), .flush_i(1'b0), .valid_i(valid2), .ready_o(ready_o2),
        .pc_i(pc2), .lane_v_i(lv2), .ir_i(ir2), .valid_o(valid_o2), .ready_i(ready2),
        .decoded_o(dec2), .illegal_o(ill2), .dec_cnt_o(cnt2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // fl = {rs1_v, rs2_v, rd_w_v, imm_v, shift_v, br_v}
    typedef struct {
        logic [31:0] ir;
        logic        lv;
        inst_type_e  t;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [5:0]  fl;
        logic        ill;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{32'h00500093, 1'b1, TypeI, 5'd1, 5'd0, 5'd5,  3'd0, 7'h00, 32'h5,        6'b101100, 1'b0};
        vecs[1]  = '{32'hFFF08113, 1'b1, TypeI, 5'd2, 5'd1, 5'd31, 3'd0, 7'h00, 32'hFFFFFFFF, 6'b101100, 1'b0};
        vecs[2]  = '{32'h40225193, 1'b1, TypeI, 5'd3, 5'd4, 5'd2,  3'd5, 7'h20, 32'h402,      6'b101110, 1'b0};
        vecs[3]  = '{32'h007302B3, 1'b1, TypeR, 5'd5, 5'd6, 5'd7,  3'd0, 7'h00, 32'h0,        6'b111000, 1'b0};
        vecs[4]  = '{32'h007312B3, 1'b1, TypeR, 5'd5, 5'd6, 5'd7,  3'd1, 7'h00, 32'h0,        6'b111010, 1'b0};
        vecs[5]  = '{32'hABCDE0B7, 1'b1, TypeU, 5'd1, 5'd0, 5'd28, 3'd0, 7'h00, 32'hABCDE000, 6'b001100, 1'b0};
        vecs[6]  = '{32'h00001117, 1'b1, TypeU, 5'd2, 5'd0, 5'd0,  3'd1, 7'h00, 32'h1000,     6'b001100, 1'b0};
        vecs[7]  = '{32'h008000EF, 1'b1, TypeJ, 5'd1, 5'd0, 5'd8,  3'd0, 7'h00, 32'h8,        6'b001100, 1'b0};
        vecs[8]  = '{32'hFFC0A067, 1'b1, TypeI, 5'd0, 5'd1, 5'd28, 3'd0, 7'h00, 32'hFFFFFFFC, 6'b101100, 1'b0};
        vecs[9]  = '{32'h00812283, 1'b1, TypeI, 5'd5, 5'd2, 5'd8,  3'd2, 7'h00, 32'h8,        6'b101100, 1'b0};
        vecs[10] = '{32'h00512623, 1'b1, TypeS, 5'd12, 5'd2, 5'd5, 3'd2, 7'h00, 32'hC,        6'b110100, 1'b0};
        vecs[11] = '{32'h00208463, 1'b1, TypeB, 5'd8, 5'd1, 5'd2,  3'd0, 7'h00, 32'h8,        6'b110101, 1'b0};
        vecs[12] = '{32'h0000000F, 1'b1, TypeE, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        6'b000000, 1'b1};
        vecs[13] = '{32'h0000000F, 1'b0, TypeE, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        6'b000000, 1'b0};
        vecs[14] = '{32'h007302B3, 1'b0, TypeR, 5'd5, 5'd6, 5'd7,  3'd0, 7'h00, 32'h0,        6'b000000, 1'b0};

        reset = 1'b1; flush = 1'b0;
        valid1 = 1'b0; ready1 = 1'b1; pc1 = '0; lv1 = '0; ir1 = '0;
        valid2 = 1'b0; ready2 = 1'b1; pc2 = '0; lv2 = '0; ir2 = '0;
        step();
        step();

        // Reset state
        chk("rst.ready_o", 64'(ready_o1), 64'd0);
        chk("rst.valid_o", 64'(valid_o1), 64'd0);
        chk("rst.cnt", 64'(cnt1), 64'd0);
        chk("rst.dec_nz", 64'(|dec1), 64'd0);
        chk("rst.ill", 64'(ill1), 64'd0);
        chk("rst.ready_o2", 64'(ready_o2), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_rel.ready_o", 64'(ready_o1), 64'd1);

        // T1: addi x1,x0,5, one-cycle latency, counter after handshake
        valid1 = 1'b1; lv1 = 1'b1; ir1 = 32'h00500093; pc1 = 32'h100;
        step();
        valid1 = 1'b0;
        chk("t1.valid_o", 64'(valid_o1), 64'd1);
        chk("t1.rd", 64'(dec1[0].rd), 64'd1);
        chk("t1.cnt_pre", 64'(cnt1), 64'd0);
        step();
        chk("t1.cnt", 64'(cnt1), 64'd1);
        chk("t1.valid_o_after", 64'(valid_o1), 64'd0);

        // Decode table, streamed at one bundle per cycle
        for (int i = 0; i < 15; i++) begin
            valid1 = 1'b1; lv1 = vecs[i].lv; ir1 = vecs[i].ir; pc1 = 32'h400 + 32'(8 * i);
            step();
            chk($sformatf("v%0d.valid_o", i), 64'(valid_o1), 64'd1);
            chk($sformatf("v%0d.v", i), 64'(dec1[0].v), 64'(vecs[i].lv));
            chk($sformatf("v%0d.pc", i), 64'(dec1[0].pc), 64'(32'h400 + 32'(8 * i)));
            chk($sformatf("v%0d.type", i), 64'(dec1[0].itype), 64'(vecs[i].t));
            chk($sformatf("v%0d.rd", i), 64'(dec1[0].rd), 64'(vecs[i].rd));
            chk($sformatf("v%0d.rs1", i), 64'(dec1[0].rs1), 64'(vecs[i].rs1));
            chk($sformatf("v%0d.rs2", i), 64'(dec1[0].rs2), 64'(vecs[i].rs2));
            chk($sformatf("v%0d.f3", i), 64'(dec1[0].funct3), 64'(vecs[i].f3));
            chk($sformatf("v%0d.f7", i), 64'(dec1[0].funct7), 64'(vecs[i].f7));
            chk($sformatf("v%0d.imm", i), 64'(dec1[0].imm), 64'(vecs[i].imm));
            chk($sformatf("v%0d.flags", i),
                64'({dec1[0].rs1_v, dec1[0].rs2_v, dec1[0].rd_w_v, dec1[0].imm_v,
                     dec1[0].shift_v, dec1[0].br_v}), 64'(vecs[i].fl));
            chk($sformatf("v%0d.ill", i), 64'(ill1), 64'(vecs[i].ill));
        end
        valid1 = 1'b0;
        step();

        // T2: two lanes, lane1 PC = pc + 4, then PC wrap
        valid2 = 1'b1; pc2 = 32'h200; lv2 = 2'b11; ir2 = {32'h00208463, 32'h000000B7};
        step();
        chk("t2.valid_o", 64'(valid_o2), 64'd1);
        chk("t2.l0.pc", 64'(dec2[0].pc), 64'h200);
        chk("t2.l0.type", 64'(dec2[0].itype), 64'(TypeU));
        chk("t2.l0.rs1", 64'(dec2[0].rs1), 64'd0);
        chk("t2.l0.f7", 64'(dec2[0].funct7), 64'd0);
        chk("t2.l0.rd_w_v", 64'(dec2[0].rd_w_v), 64'd1);
        chk("t2.l1.pc", 64'(dec2[1].pc), 64'h204);
        chk("t2.l1.type", 64'(dec2[1].itype), 64'(TypeB));
        chk("t2.l1.br_v", 64'(dec2[1].br_v), 64'd1);
        chk("t2.l1.rd_w_v", 64'(dec2[1].rd_w_v), 64'd0);
        chk("t2.ill", 64'(ill2), 64'd0);
        pc2 = 32'hFFFFFFFC; lv2 = 2'b10;
        step();
        valid2 = 1'b0;
        chk("t2.wrap.pc", 64'(dec2[1].pc), 64'h0);
        chk("t2.wrap.l0v", 64'(dec2[0].v), 64'd0);
        chk("t2.cnt_a", 64'(cnt2), 64'd2);
        step();
        chk("t2.cnt_b", 64'(cnt2), 64'd3);

        // T3: three bundles against a stalled consumer, then release
        do_reset();
        ready1 = 1'b0; valid1 = 1'b1; lv1 = 1'b1; ir1 = 32'h00500093;
        pc1 = 32'h10;
        step();
        chk("t3.ready_a", 64'(ready_o1), 64'd1);
        pc1 = 32'h14;
        step();
        chk("t3.ready_b", 64'(ready_o1), 64'd0);
        pc1 = 32'h18;
        step();
        chk("t3.hold.valid", 64'(valid_o1), 64'd1);
        chk("t3.hold.pc", 64'(dec1[0].pc), 64'h10);
        ready1 = 1'b1;
        step();
        chk("t3.out2.pc", 64'(dec1[0].pc), 64'h14);
        chk("t3.out2.ready", 64'(ready_o1), 64'd1);
        step();
        valid1 = 1'b0;
        chk("t3.out3.pc", 64'(dec1[0].pc), 64'h18);
        chk("t3.out3.valid", 64'(valid_o1), 64'd1);
        step();
        chk("t3.empty", 64'(valid_o1), 64'd0);
        chk("t3.cnt", 64'(cnt1), 64'd3);

        // T5: flush with OR and SK full, downstream handshake in the flush cycle still counts
        do_reset();
        ready1 = 1'b0; valid1 = 1'b1; lv1 = 1'b1; pc1 = 32'h20;
        step();
        pc1 = 32'h24;
        step();
        chk("t5.full", 64'(ready_o1), 64'd0);
        flush = 1'b1; ready1 = 1'b1; pc1 = 32'h28;
        step();
        flush = 1'b0; valid1 = 1'b0;
        chk("t5.valid_o", 64'(valid_o1), 64'd0);
        chk("t5.ready_o", 64'(ready_o1), 64'd1);
        chk("t5.cnt", 64'(cnt1), 64'd1);
        step();
        chk("t5.dropped", 64'(valid_o1), 64'd0);
        chk("t5.cnt_hold", 64'(cnt1), 64'd1);

        // T6: 20 valid lanes saturate a 4-bit counter, then reset mid-stream
        do_reset();
        ready1 = 1'b1; valid1 = 1'b1; lv1 = 1'b1; ir1 = 32'h00500093; pc1 = 32'h40;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 14) chk("t6.cnt14", 64'(cnt1), 64'd14);
        end
        chk("t6.sat", 64'(cnt1), 64'd15);
        reset = 1'b1;
        step();
        chk("t6.rst.cnt", 64'(cnt1), 64'd0);
        chk("t6.rst.valid_o", 64'(valid_o1), 64'd0);
        chk("t6.rst.ready_o", 64'(ready_o1), 64'd0);
        chk("t6.rst.dec_nz", 64'(|dec1), 64'd0);
        reset = 1'b0; lv1 = 1'b0;
        #1;
        chk("t6.rel.ready_o", 64'(ready_o1), 64'd1);
        step();
        lv1 = 1'b1;
        chk("t6.lv0.valid_o", 64'(valid_o1), 64'd1);
        step();
        valid1 = 1'b0;
        chk("t6.lv0.cnt", 64'(cnt1), 64'd0);
        step();
        chk("t6.lv1.cnt", 64'(cnt1), 64'd1);
        chk("t6.end.valid_o", 64'(valid_o1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
